alu_cmd_responder: RTL and testbench
====================================

// Module: alu_cmd_responder
// PURPOSE
//  Handshaked responder for ALU operations: accepts {A,B,sel} commands on a
//  valid/ready channel and returns {Y,carry,err} on a valid/ready response
//  channel. Opcodes match the mux-based ALU: 000 ADD, 001 SUB, 010 AND,
//  011 OR, 100 XOR.
//  A 2-entry response buffer decouples the channels so a stalled consumer
//  never corrupts results.
//  Sits between a command initiator (bench or sequencer) and result consumer.
// PARAMETERS
//  W        4   operand/result width in bits
//  CNT_W    16  width of accepted-command counter (saturating)
//  ERR_W    8   width of illegal-opcode counter (saturating)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      responder can accept command this cycle
//  cmd_a      in   W      operand A
//  cmd_b      in   W      operand B
//  cmd_sel    in   3      opcode
//  rsp_valid  out  1      response present at buffer head
//  rsp_ready  in   1      consumer takes response this cycle
//  rsp_y      out  W      result, modulo 2^W
//  rsp_sel    out  3      opcode echoed with result
//  rsp_c      out  1      ADD: carry out; SUB: borrow (A<B unsigned); else 0
//  rsp_err    out  1      1 = opcode 101..111 (illegal); rsp_y = 0
//  op_cnt     out  CNT_W  accepted commands, saturates at all-ones
//  err_cnt    out  ERR_W  accepted illegal commands, saturates at all-ones
// BEHAVIOUR
//  - Reset (async, immediate): buffer emptied, rsp_valid=0, rsp_y/rsp_sel/
//    rsp_c/rsp_err=0, op_cnt=0, err_cnt=0; cmd_ready=0 while rst high.
//  - Accept on posedge when cmd_valid & cmd_ready. Result is computed
//    combinationally from cmd_* and written into the buffer on that edge.
//  - Latency: response valid the cycle after acceptance (1 cycle) if buffer
//    was empty; otherwise behind older entries, strict FIFO order.
//  - cmd_ready = ~rst & (count != 2); no combinational path from rsp_ready.
//  - Pop on posedge when rsp_valid & rsp_ready. rsp_* outputs come from
//    buffer head (registered); hold stable while rsp_valid & ~rsp_ready.
//  - count: 0,1,2. Push only: +1. Pop only: -1. Push+pop at count 1: stays
//    1, head advances to the new entry. At count 2 push is impossible.
//  - Sustains 1 cmd/cycle when rsp_ready held high.
//  - Arithmetic: ADD {c,y}=A+B (W+1 bits); SUB y=A-B mod 2^W, c=(A<B);
//    logic ops bitwise, c=0. Illegal opcode: y=0, c=0, err=1.
//  - Counters increment on acceptance only; err_cnt only when err=1.
//    Both saturate, never wrap.
//  - Reset mid-operation discards buffered results; no response emitted
//    for commands accepted before reset.
// STRUCTURE
//  - Package alu_pkg: opcode localparams OP_ADD..OP_XOR, OP_W=3, and a
//    function is_legal_op(sel).
//  - Sub-module alu_rsp_fifo: 2-entry FIFO (push/pop, count, full/empty),
//    data width W+3+1+1. Compute logic and counters stay in top.
// TESTING
//  1. A=0101,B=0011, sel 000..100 back-to-back, rsp_ready=1 -> y=1000,0010,
//     0001,0111,0110; c=0 all; one response per cycle, 1-cycle latency.
//  2. ADD A=1111,B=0001 -> y=0000,c=1; SUB A=0011,B=0101 -> y=1110,c=1.
//  3. sel=101,110,111 -> y=0000,err=1 each; err_cnt=3, op_cnt=3.
//  4. rsp_ready=0, offer 3 cmds -> 2 accepted, cmd_ready=0 on third and
//     outputs stable; raise rsp_ready -> third accepted, order preserved.
//  5. count=1, push and pop same edge -> count stays 1, next head correct.
//  6. Buffer holding 2 entries, assert rst mid-cycle -> rsp_valid=0 before
//     next edge, counters 0; after release first new cmd returns in 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ALU command responder.
// Opcodes 101..111 are reserved and reported as illegal.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;

  function automatic logic is_legal_op(input logic [OP_W-1:0] sel);
    return (sel <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Two-entry response FIFO between ALU compute and the response channel.
// The head is read straight from storage registers, so outputs are glitch-free.
module alu_rsp_fifo #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [1:0]    count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is reset too, so the head reads as all-zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_responder.sv
// Valid/ready ALU command responder: results computed on acceptance and
// queued in a 2-entry FIFO so a stalled consumer never loses a result.
module alu_cmd_responder
  import alu_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [OP_W-1:0]  cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_y,
  output logic [OP_W-1:0]  rsp_sel,
  output logic             rsp_c,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  typedef struct packed {
    logic [W-1:0]    y;
    logic [OP_W-1:0] sel;
    logic            c;
    logic            err;
  } rsp_t;

  rsp_t       res;
  rsp_t       head;
  logic       accept;
  logic       pop;
  logic       full;
  logic       empty;
  logic [1:0] count;

  // Readiness depends only on FIFO occupancy, never on rsp_ready.
  assign cmd_ready = ~rst & ~full;
  assign accept    = cmd_valid & cmd_ready;
  assign rsp_valid = ~empty;
  assign pop       = rsp_valid & rsp_ready;

  // NOTE: every field gets a default first so no latch is inferred.
  always_comb begin
    res     = '0;
    res.sel = cmd_sel;
    res.err = ~is_legal_op(cmd_sel);
    case (cmd_sel)
      OP_ADD: {res.c, res.y} = {1'b0, cmd_a} + {1'b0, cmd_b};
      OP_SUB: begin
        res.y = cmd_a - cmd_b;
        res.c = (cmd_a < cmd_b);
      end
      OP_AND:  res.y = cmd_a & cmd_b;
      OP_OR:   res.y = cmd_a | cmd_b;
      OP_XOR:  res.y = cmd_a ^ cmd_b;
      default: res.y = '0;
    endcase
  end

  alu_rsp_fifo #(.DW($bits(rsp_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (res),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign rsp_y   = head.y;
  assign rsp_sel = head.sel;
  assign rsp_c   = head.c;
  assign rsp_err = head.err;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      if (op_cnt != '1) op_cnt <= op_cnt + CNT_W'(1);
      if (res.err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_alu_cmd_responder;

  localparam int W     = 4;
  localparam int CNT_W = 16;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [W-1:0]     cmd_a;
  logic [W-1:0]     cmd_b;
  logic [2:0]       cmd_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_y;
  logic [2:0]       rsp_sel;
  logic             rsp_c;
  logic             rsp_err;
  logic [CNT_W-1:0] op_cnt;
  logic [ERR_W-1:0] err_cnt;

  alu_cmd_responder #(.W(W), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_sel   (rsp_sel),
    .rsp_c     (rsp_c),
    .rsp_err   (rsp_err),
    .op_cnt    (op_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int y;
    int sel;
    int c;
    int err;
  } exp_t;

  exp_t q[$];
  int   m_op  = 0;
  int   m_err = 0;
  bit   m_acc;
  bit   m_pop;
  exp_t m_new;

  function automatic exp_t ref_alu(input int a, input int b, input int sel);
    exp_t r;
    int   m;
    m     = 1 << W;
    r.sel = sel;
    r.c   = 0;
    r.err = 0;
    r.y   = 0;
    case (sel)
      0: begin r.y = (a + b) % m;     r.c = (a + b >= m) ? 1 : 0; end
      1: begin r.y = (a - b + m) % m; r.c = (a < b) ? 1 : 0;      end
      2: r.y = a & b;
      3: r.y = a | b;
      4: r.y = a ^ b;
      default: r.err = 1;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_op  = 0;
      m_err = 0;
    end else begin
      m_acc = cmd_valid && (q.size() < 2);
      m_pop = rsp_ready && (q.size() > 0);
      if (m_pop) void'(q.pop_front());
      if (m_acc) begin
        m_new = ref_alu(int'(cmd_a), int'(cmd_b), int'(cmd_sel));
        q.push_back(m_new);
        m_op++;
        if (m_new.err != 0) m_err++;
      end
    end
  end

  always @(negedge clk) begin
    check("cmd_ready", cmd_ready, (!rst && q.size() < 2) ? 1 : 0);
    check("rsp_valid", rsp_valid, (q.size() > 0) ? 1 : 0);
    if (q.size() > 0) begin
      check("rsp_y",   rsp_y,   q[0].y);
      check("rsp_sel", rsp_sel, q[0].sel);
      check("rsp_c",   rsp_c,   q[0].c);
      check("rsp_err", rsp_err, q[0].err);
    end
    check("op_cnt",  op_cnt,  (m_op  > 65535) ? 65535 : m_op);
    check("err_cnt", err_cnt, (m_err > 255)   ? 255   : m_err);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int a, input int b, input int sel);
    cmd_valid = v;
    cmd_a     = W'(a);
    cmd_b     = W'(b);
    cmd_sel   = 3'(sel);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int y_lit [5] = '{8, 2, 1, 7, 6};

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    drive(1'b0, 0, 0, 0);
    #1;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset cmd_ready", cmd_ready, 0);
    check("reset rsp_y",     rsp_y,     0);
    check("reset op_cnt",    op_cnt,    0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // 1: all legal opcodes back-to-back, one response per cycle
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5, 3, i);
      step();
      check("t1 valid", rsp_valid, 1);
      check("t1 y",     rsp_y,     y_lit[i]);
      check("t1 c",     rsp_c,     0);
    end
    drive(1'b0, 0, 0, 0);
    step();

    // 2: carry and borrow
    drive(1'b1, 15, 1, 0);
    step();
    check("t2 add y", rsp_y, 0);
    check("t2 add c", rsp_c, 1);
    drive(1'b1, 3, 5, 1);
    step();
    check("t2 sub y", rsp_y, 14);
    check("t2 sub c", rsp_c, 1);
    drive(1'b0, 0, 0, 0);
    step();

    // 3: illegal opcodes
    pulse_reset();
    for (int s = 5; s < 8; s++) begin
      drive(1'b1, 9, 6, s);
      step();
      check("t3 y",   rsp_y,   0);
      check("t3 err", rsp_err, 1);
    end
    drive(1'b0, 0, 0, 0);
    step();
    check("t3 err_cnt", err_cnt, 3);
    check("t3 op_cnt",  op_cnt,  3);

    // 4: stalled consumer, third command blocked
    rsp_ready = 1'b0;
    drive(1'b1, 1, 2, 0);
    step();
    drive(1'b1, 3, 4, 0);
    step();
    drive(1'b1, 5, 6, 0);
    check("t4 blocked", cmd_ready, 0);
    check("t4 head",    rsp_y,     3);
    step();
    check("t4 held",    rsp_y,     3);
    rsp_ready = 1'b1;
    step();
    check("t4 second",  rsp_y,     7);
    check("t4 ready",   cmd_ready, 1);
    step();
    check("t4 third",   rsp_y,     11);
    drive(1'b0, 0, 0, 0);
    step();
    check("t4 drained", rsp_valid, 0);

    // 5: push and pop on the same edge at count 1
    rsp_ready = 1'b0;
    drive(1'b1, 2, 2, 0);
    step();
    rsp_ready = 1'b1;
    drive(1'b1, 6, 1, 1);
    step();
    check("t5 valid", rsp_valid, 1);
    check("t5 y",     rsp_y,     5);
    check("t5 ready", cmd_ready, 1);
    drive(1'b0, 0, 0, 0);
    step();
    check("t5 empty", rsp_valid, 0);

    // 6: asynchronous reset with a full buffer
    rsp_ready = 1'b0;
    drive(1'b1, 2, 3, 0);
    step();
    drive(1'b1, 7, 1, 0);
    step();
    drive(1'b0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("t6 rsp_valid", rsp_valid, 0);
    check("t6 rsp_y",     rsp_y,     0);
    check("t6 op_cnt",    op_cnt,    0);
    check("t6 cmd_ready", cmd_ready, 0);
    step();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b1, 9, 4, 3);
    step();
    check("t6 new valid", rsp_valid, 1);
    check("t6 new y",     rsp_y,     13);
    drive(1'b0, 0, 0, 0);
    step();

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    // err_cnt saturation
    pulse_reset();
    rsp_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      drive(1'b1, 0, 0, 5 + (n % 3));
      step();
    end
    drive(1'b0, 0, 0, 0);
    step();
    check("sat err_cnt", err_cnt, 255);
    check("sat op_cnt",  op_cnt,  300);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
